// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: instruction kinds, pipeline slot
// record and MDU countdown width.
package hazard_pkg;

    localparam int unsigned MDU_CNT_W = 4;
    localparam int unsigned RD_W      = 5;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MDU  = 2'd2
    } kind_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        kind_t           kind;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, regwrite: 1'b0, kind: KIND_ALU};

    // The reserved encoding 3 behaves exactly like an ALU op.
    function automatic kind_t decode_kind(input logic [1:0] k);
        case (k)
            2'd1:    return KIND_LOAD;
            2'd2:    return KIND_MDU;
            default: return KIND_ALU;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/destination info and flush in, pipeline register
// enable controls out.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic [1:0]            id_kind;
    logic                  flush;

    logic                  stall_if_id;
    logic                  bubble_id_ex;
    logic                  hold_ex;
    logic                  bubble_ex_mem;
    logic                  mdu_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_kind, flush,
        input  stall_if_id, bubble_id_ex, hold_ex, bubble_ex_mem, mdu_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_kind, flush,
        output stall_if_id, bubble_id_ex, hold_ex, bubble_ex_mem, mdu_busy
    );
endinterface

// File: rtl/mdu_busy_timer.sv
// Countdown of remaining MDU occupancy cycles in EX; busy while nonzero,
// last on the final busy cycle.
module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic busy,
    output logic last
);
    logic [MDU_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= MDU_CNT_W'(MDU_LATENCY - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - MDU_CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);
    assign last = (cnt == MDU_CNT_W'(1));
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM producers and raises stall/bubble/hold controls only for
// load-use dependencies and an occupied multi-cycle MDU.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  hz
);
    slot_t ex_slot;
    slot_t mem_slot;
    logic  busy;
    logic  mdu_last;
    logic  load_use;
    logic  issue;
    logic  mdu_load;
    kind_t id_kind_dec;

    function automatic logic producer_match(input slot_t s, input logic [REG_ADDR_W-1:0] src,
                                            input logic used, input logic id_valid);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == RD_W'(src)) && used && id_valid;
    endfunction

    always_comb begin
        id_kind_dec = decode_kind(hz.id_kind);
        load_use    = !busy && (ex_slot.kind == KIND_LOAD) &&
                      (producer_match(ex_slot, hz.id_rs1, hz.id_rs1_used, hz.id_valid) ||
                       producer_match(ex_slot, hz.id_rs2, hz.id_rs2_used, hz.id_valid));
        issue       = !hz.flush && !busy && hz.id_valid && !load_use;
        mdu_load    = issue && (id_kind_dec == KIND_MDU);
    end

    mdu_busy_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mdu_load),
        .clear (hz.flush),
        .busy  (busy),
        .last  (mdu_last)
    );

    assign hz.stall_if_id   = busy || load_use;
    assign hz.bubble_id_ex  = load_use;
    assign hz.hold_ex       = busy;
    assign hz.bubble_ex_mem = busy;
    assign hz.mdu_busy      = busy;

    // A flushed in-progress MDU is aborted rather than retired into MEM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
        end else if (hz.flush) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= busy ? SLOT_EMPTY : ex_slot;
        end else if (busy) begin
            mem_slot <= SLOT_EMPTY;
        end else begin
            mem_slot <= ex_slot;
            if (issue) begin
                ex_slot <= '{valid: 1'b1, rd: RD_W'(hz.id_rd),
                             regwrite: hz.id_regwrite, kind: id_kind_dec};
            end else begin
                ex_slot <= SLOT_EMPTY;
            end
        end
    end

    mdu_release: assert property (@(posedge clk) disable iff (!rst_n) mdu_last |=> !busy);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard against an
// issue-time based reference model.
module tb_hazard_scoreboard;
    localparam int unsigned LAT = 4;
    localparam int unsigned AW  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(AW)) hz ();

    hazard_scoreboard #(
        .MDU_LATENCY (LAT),
        .REG_ADDR_W  (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct {
        bit valid;
        int rd;
        bit rw;
        int kind;
    } inflight_t;

    inflight_t ex_instr;
    longint    cyc;
    longint    mdu_end;
    bit        m_stalled;
    int        n_checks = 0;
    int        n_pass   = 0;
    logic      last_stall, last_bubble, last_hold, last_bem, last_busy;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic bit feeds(input inflight_t p, input int src, input bit used, input bit idv);
        return idv && p.valid && p.rw && p.rd != 0 && p.rd == src && used;
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rw, input int kind);
        hz.id_valid    = v;
        hz.id_rs1      = AW'(rs1);
        hz.id_rs1_used = u1;
        hz.id_rs2      = AW'(rs2);
        hz.id_rs2_used = u2;
        hz.id_rd       = AW'(rd);
        hz.id_regwrite = rw;
        hz.id_kind     = 2'(kind);
    endtask

    task automatic run_cycle();
        bit busy, lu;
        int kind;
        busy = (cyc < mdu_end);
        lu   = !busy && ex_instr.kind == 1 &&
               (feeds(ex_instr, int'(hz.id_rs1), hz.id_rs1_used, hz.id_valid) ||
                feeds(ex_instr, int'(hz.id_rs2), hz.id_rs2_used, hz.id_valid));
        m_stalled = busy || lu;
        @(negedge clk);
        check("stall_if_id",   8'(hz.stall_if_id),   8'(busy || lu));
        check("bubble_id_ex",  8'(hz.bubble_id_ex),  8'(lu));
        check("hold_ex",       8'(hz.hold_ex),       8'(busy));
        check("bubble_ex_mem", 8'(hz.bubble_ex_mem), 8'(busy));
        check("mdu_busy",      8'(hz.mdu_busy),      8'(busy));
        last_stall = hz.stall_if_id; last_bubble = hz.bubble_id_ex;
        last_hold = hz.hold_ex; last_bem = hz.bubble_ex_mem; last_busy = hz.mdu_busy;
        @(posedge clk);
        kind = (int'(hz.id_kind) == 3) ? 0 : int'(hz.id_kind);
        if (!rst_n || hz.flush) begin
            ex_instr.valid = 0;
            mdu_end = 0;
        end else if (!busy) begin
            if (hz.id_valid && !lu) begin
                ex_instr = '{valid: 1, rd: int'(hz.id_rd), rw: hz.id_regwrite, kind: kind};
                if (kind == 2) mdu_end = cyc + 1 + (LAT - 1);
            end else begin
                ex_instr.valid = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        ex_instr = '{valid: 0, rd: 0, rw: 0, kind: 0};
        cyc = 0; mdu_end = 0;
        rst_n = 1'b0; hz.flush = 1'b0;
        set_id(1, 5, 1, 6, 1, 7, 1, 0);
        @(posedge clk); #1;
        run_cycle();
        check("reset_stall", 8'(last_stall), 8'd0);
        check("reset_busy",  8'(last_busy),  8'd0);
        rst_n = 1'b1;
        idle(1);

        // lw x5 ; add x6,x5,x1
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        set_id(1, 5, 1, 1, 1, 6, 1, 0); run_cycle();
        check("lu_stall",  8'(last_stall),  8'd1);
        check("lu_bubble", 8'(last_bubble), 8'd1);
        run_cycle();
        check("lu_release", 8'(last_stall), 8'd0);
        idle(2);

        // add x5 ; sub x7,x5,x5
        set_id(1, 1, 1, 2, 1, 5, 1, 0); run_cycle();
        set_id(1, 5, 1, 5, 1, 7, 1, 0); run_cycle();
        check("alu_fwd_stall", 8'(last_stall), 8'd0);
        idle(2);

        // lw x0 ; user of x0
        set_id(1, 0, 0, 0, 0, 0, 1, 1); run_cycle();
        set_id(1, 0, 1, 0, 1, 7, 1, 0); run_cycle();
        check("x0_stall", 8'(last_stall), 8'd0);
        idle(2);

        // lw x5 ; lui x5 with rs1 unused
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        set_id(1, 5, 0, 0, 0, 5, 1, 0); run_cycle();
        check("unused_src_stall", 8'(last_stall), 8'd0);
        idle(2);

        // mul x8 ; add x9,x8,x0
        set_id(1, 1, 1, 2, 1, 8, 1, 2); run_cycle();
        set_id(1, 8, 1, 0, 1, 9, 1, 0);
        for (int i = 1; i <= int'(LAT) - 1; i++) begin
            run_cycle();
            check("mdu_hold", 8'(last_hold), 8'd1);
            check("mdu_bem",  8'(last_bem),  8'd1);
            check("mdu_bub",  8'(last_bubble), 8'd0);
        end
        run_cycle();
        check("mdu_release_stall", 8'(last_stall), 8'd0);
        check("mdu_release_busy",  8'(last_busy),  8'd0);
        idle(2);

        // flush at cnt=2
        set_id(1, 1, 1, 2, 1, 8, 1, 2); run_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
        hz.flush = 1'b1; run_cycle();
        hz.flush = 1'b0; run_cycle();
        check("flush_mdu_busy", 8'(last_busy),  8'd0);
        check("flush_mdu_hold", 8'(last_hold),  8'd0);
        idle(2);

        // flush coincident with load-use
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        hz.flush = 1'b1; run_cycle();
        check("flush_lu_stall_in", 8'(last_stall), 8'd1);
        hz.flush = 1'b0; run_cycle();
        check("flush_lu_linger", 8'(last_stall), 8'd0);
        idle(2);

        // reset mid-hold with dependent instruction waiting
        set_id(1, 1, 1, 2, 1, 8, 1, 2); run_cycle();
        set_id(1, 8, 1, 8, 1, 9, 1, 0); run_cycle();
        rst_n = 1'b0; run_cycle();
        rst_n = 1'b1; run_cycle();
        check("rst_mid_busy",  8'(last_busy),  8'd0);
        check("rst_mid_stall", 8'(last_stall), 8'd0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if (!m_stalled || !hz.id_valid) begin
                int k;
                k = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 2) == 0) ? 1 : 0);
                if ($urandom_range(0, 9) == 0) k = 3;
                set_id($urandom_range(0, 7) != 0,
                       $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 5) != 0, k);
            end
            hz.flush = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 63) != 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
